// File: rtl/uart_block_assembler.sv
// rtl/uart_block_assembler.sv - packs UART receive bytes into fixed-width blocks for the AES core
// Three-state packer (IDLE/FILL/HOLD) with flush padding, inter-byte timeout and overrun pulses.
module uart_block_assembler #(
   parameter int         NUM_BYTES      = 14,
   parameter bit         MSB_FIRST      = 1'b1,
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [7:0] PAD_BYTE       = 8'h00
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [7:0]                       rx_data,
   input  logic                             rx_valid,
   input  logic                             flush,
   output logic [8*NUM_BYTES-1:0]           block_data,
   output logic                             block_valid,
   input  logic                             block_ready,
   output logic [$clog2(NUM_BYTES+1)-1:0]   byte_count,
   output logic                             timeout,
   output logic                             overrun
);

   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int BW = 8 * NUM_BYTES;
   localparam logic [CW-1:0] NB       = CW'(NUM_BYTES);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_HOLD} state_t;

   state_t         state_q, state_d;
   logic [BW-1:0]  data_q, data_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [TW-1:0]  tcnt_q, tcnt_d;
   logic           timeout_q, timeout_d;
   logic           overrun_q, overrun_d;
   logic [CW-1:0]  pos;

   // Position k maps to a byte lane according to the configured byte order.
   function automatic logic [BW-1:0] put_byte(input logic [BW-1:0] blk,
                                              input logic [CW-1:0] k,
                                              input logic [7:0]    b);
      logic [BW-1:0] r;
      int            off;
      r   = blk;
      off = MSB_FIRST ? (NUM_BYTES - 1 - int'(k)) : int'(k);
      r[8*off +: 8] = b;
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      tcnt_d    = tcnt_q;
      timeout_d = 1'b0;
      overrun_d = 1'b0;
      pos       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            tcnt_d = '0;
            if (rx_valid) begin
               data_d  = put_byte('0, '0, rx_data);
               cnt_d   = CW'(1);
               state_d = (NUM_BYTES == 1) ? ST_HOLD : ST_FILL;
            end
         end
         ST_FILL: begin
            if (rx_valid) begin
               data_d = put_byte(data_q, cnt_q, rx_data);
               pos    = cnt_q + 1'b1;
            end
            if (pos == NB) begin
               cnt_d   = pos;
               tcnt_d  = '0;
               state_d = ST_HOLD;
            end else if (flush) begin
               // Padding starts after any byte stored in this same cycle.
               for (int i = 0; i < NUM_BYTES; i++) begin
                  if (i >= int'(pos)) data_d = put_byte(data_d, CW'(i), PAD_BYTE);
               end
               cnt_d   = NB;
               tcnt_d  = '0;
               state_d = ST_HOLD;
            end else if (rx_valid) begin
               cnt_d  = pos;
               tcnt_d = '0;
            end else if ((TIMEOUT_CYCLES > 0) && (tcnt_q >= TO_LIMIT - 1'b1)) begin
               data_d    = '0;
               cnt_d     = '0;
               tcnt_d    = '0;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (TIMEOUT_CYCLES > 0) begin
               tcnt_d = (tcnt_q == TO_LIMIT) ? tcnt_q : tcnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            tcnt_d = '0;
            if (block_ready) begin
               data_d  = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
               // Zero-bubble: a byte arriving with acceptance opens the next block.
               if (rx_valid) begin
                  data_d  = put_byte('0, '0, rx_data);
                  cnt_d   = CW'(1);
                  state_d = (NUM_BYTES == 1) ? ST_HOLD : ST_FILL;
               end
            end else if (rx_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            data_d  = '0;
            cnt_d   = '0;
            tcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         cnt_q     <= '0;
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
      end
   end

   assign block_data  = data_q;
   assign block_valid = (state_q == ST_HOLD);
   assign byte_count  = cnt_q;
   assign timeout     = timeout_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_block_assembler.sv
// tb/tb_uart_block_assembler.sv - scoreboard bench for uart_block_assembler over three parameter sets
module tb_uart_block_assembler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [7:0]   rx_d [3];
   logic         rx_v [3];
   logic         fl   [3];
   logic         rdy  [3];
   logic         bv   [3];
   logic         to   [3];
   logic         ov   [3];
   logic [111:0] bd_a;
   logic [31:0]  bd_b, bd_c;
   logic [3:0]   cnt_a;
   logic [2:0]   cnt_b, cnt_c;

   logic [115:0] q0 [$];
   logic [34:0]  q1 [$];
   logic [34:0]  q2 [$];

   int n_pass  = 0;
   int n_total = 0;

   uart_block_assembler u_a (
      .clk(clk), .reset(reset), .rx_data(rx_d[0]), .rx_valid(rx_v[0]), .flush(fl[0]),
      .block_data(bd_a), .block_valid(bv[0]), .block_ready(rdy[0]), .byte_count(cnt_a),
      .timeout(to[0]), .overrun(ov[0])
   );

   uart_block_assembler #(.NUM_BYTES(4), .MSB_FIRST(1'b0)) u_b (
      .clk(clk), .reset(reset), .rx_data(rx_d[1]), .rx_valid(rx_v[1]), .flush(fl[1]),
      .block_data(bd_b), .block_valid(bv[1]), .block_ready(rdy[1]), .byte_count(cnt_b),
      .timeout(to[1]), .overrun(ov[1])
   );

   uart_block_assembler #(.NUM_BYTES(4), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(20), .PAD_BYTE(8'h5A)) u_c (
      .clk(clk), .reset(reset), .rx_data(rx_d[2]), .rx_valid(rx_v[2]), .flush(fl[2]),
      .block_data(bd_c), .block_valid(bv[2]), .block_ready(rdy[2]), .byte_count(cnt_c),
      .timeout(to[2]), .overrun(ov[2])
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int s, input logic [7:0] b);
      rx_d[s] = b;
      rx_v[s] = 1'b1;
      tick();
      rx_v[s] = 1'b0;
   endtask

   task automatic accept(input int s);
      rdy[s] = 1'b1;
      tick();
      rdy[s] = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1 && bv[0] === 1'b1 && rdy[0] === 1'b1) begin
         if (q0.size() == 0) chk("a_unexpected_block", 1, 0);
         else chk("a_block", {cnt_a, bd_a}, q0.pop_front());
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1 && bv[1] === 1'b1 && rdy[1] === 1'b1) begin
         if (q1.size() == 0) chk("b_unexpected_block", 1, 0);
         else chk("b_block", {cnt_b, bd_b}, q1.pop_front());
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1 && bv[2] === 1'b1 && rdy[2] === 1'b1) begin
         if (q2.size() == 0) chk("c_unexpected_block", 1, 0);
         else chk("c_block", {cnt_c, bd_c}, q2.pop_front());
      end
   end

   initial begin
      logic seen;
      reset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         rx_d[s] = 8'h00; rx_v[s] = 1'b0; fl[s] = 1'b0; rdy[s] = 1'b0;
      end
      repeat (5) tick();
      chk("rst_a", {bd_a, bv[0], cnt_a, to[0], ov[0]}, 0);
      chk("rst_b", {bd_b, bv[1], cnt_b, to[1], ov[1]}, 0);
      chk("rst_c", {bd_c, bv[2], cnt_c, to[2], ov[2]}, 0);
      reset = 1'b1;
      tick();

      // Default 14-byte MSB-first block
      for (int i = 1; i <= 14; i++) begin
         send(0, 8'(i));
         if (i == 13) chk("a_not_valid_at_13", {bv[0], cnt_a}, {1'b0, 4'd13});
      end
      chk("a_valid", bv[0], 1'b1);
      chk("a_cnt", cnt_a, 4'd14);
      q0.push_back({4'd14, 112'h0102030405060708090A0B0C0D0E});
      accept(0);
      chk("a_idle", {bv[0], cnt_a, bd_a}, 0);

      // LSB-first with stalled downstream and overrun
      send(1, 8'hAA); send(1, 8'hBB); send(1, 8'hCC); send(1, 8'hDD);
      q1.push_back({3'd4, 32'hDDCCBBAA});
      for (int i = 0; i < 10; i++) begin
         chk("b_hold", {bv[1], cnt_b, bd_b}, {1'b1, 3'd4, 32'hDDCCBBAA});
         tick();
      end
      send(1, 8'hEE);
      chk("b_overrun", {ov[1], to[1]}, 2'b10);
      chk("b_hold_after_ovr", {bv[1], cnt_b, bd_b}, {1'b1, 3'd4, 32'hDDCCBBAA});
      tick();
      chk("b_overrun_pulse", ov[1], 1'b0);
      accept(1);
      chk("b_idle", {bv[1], cnt_b, bd_b}, 0);

      // Flush together with a byte pads the remainder
      send(2, 8'h11); send(2, 8'h22);
      rx_d[2] = 8'h33; rx_v[2] = 1'b1; fl[2] = 1'b1;
      tick();
      rx_v[2] = 1'b0; fl[2] = 1'b0;
      chk("c_flush", {bv[2], cnt_c, bd_c}, {1'b1, 3'd4, 32'h1122335A});
      q2.push_back({3'd4, 32'h1122335A});
      accept(2);
      fl[2] = 1'b1;
      tick();
      fl[2] = 1'b0;
      chk("c_idle_flush_ignored", {bv[2], cnt_c, bd_c}, 0);

      // Timeout 20 clocks after the last byte
      send(2, 8'h01); send(2, 8'h02);
      seen = 1'b0;
      for (int i = 1; i <= 19; i++) begin
         tick();
         seen |= to[2];
      end
      chk("c_no_early_timeout", {seen, cnt_c}, {1'b0, 3'd2});
      tick();
      chk("c_timeout", {to[2], ov[2], bv[2], cnt_c, bd_c}, {1'b1, 1'b0, 1'b0, 3'd0, 32'd0});
      tick();
      chk("c_timeout_pulse", to[2], 1'b0);
      send(2, 8'hA1); send(2, 8'hA2); send(2, 8'hA3); send(2, 8'hA4);
      q2.push_back({3'd4, 32'hA1A2A3A4});
      accept(2);

      // Zero-bubble acceptance with a new byte
      send(2, 8'hB1); send(2, 8'hB2); send(2, 8'hB3); send(2, 8'hB4);
      q2.push_back({3'd4, 32'hB1B2B3B4});
      rdy[2] = 1'b1; rx_d[2] = 8'h77; rx_v[2] = 1'b1;
      tick();
      rdy[2] = 1'b0; rx_v[2] = 1'b0;
      chk("c_b2b", {bv[2], cnt_c, ov[2], bd_c}, {1'b0, 3'd1, 1'b0, 32'h77000000});
      send(2, 8'h78); send(2, 8'h79); send(2, 8'h7A);
      q2.push_back({3'd4, 32'h7778797A});
      accept(2);

      // Reset in the middle of a block
      send(2, 8'hC1); send(2, 8'hC2); send(2, 8'hC3);
      reset = 1'b0;
      tick();
      chk("c_mid_reset", {bd_c, bv[2], cnt_c, to[2], ov[2]}, 0);
      reset = 1'b1;
      tick();
      send(2, 8'hD1); send(2, 8'hD2); send(2, 8'hD3); send(2, 8'hD4);
      q2.push_back({3'd4, 32'hD1D2D3D4});
      accept(2);
      tick();

      chk("a_queue_drained", q0.size(), 0);
      chk("b_queue_drained", q1.size(), 0);
      chk("c_queue_drained", q2.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
